// File: rtl/eq_checker_pkg.sv
// Shared types for equation_checker: FSM states, ALU micro-ops and the
// per-mode micro-program table.
package eq_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_WAIT,
    CALC,
    COMPARE,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    MUL,
    DIV,
    NOP
  } alu_op_e;

  typedef enum logic [1:0] {
    X,
    Y,
    Z,
    R
  } reg_sel_e;

  typedef struct packed {
    alu_op_e  op;
    reg_sel_e src_a;
    reg_sel_e src_b;
    reg_sel_e dst;
  } micro_op_t;

  localparam micro_op_t UOP_NOP = '{op: NOP, src_a: X, src_b: X, dst: X};

  // Four-step micro-program per mode; unused trailing steps are NOPs.
  function automatic micro_op_t get_uop(input logic [1:0] mode, input logic [1:0] step);
    micro_op_t u;
    u = UOP_NOP;
    case ({mode, step})
      4'b00_00: u = '{op: DIV, src_a: X, src_b: Z, dst: X};
      4'b00_01: u = '{op: MUL, src_a: X, src_b: X, dst: X};
      4'b00_10: u = '{op: DIV, src_a: Y, src_b: Z, dst: Y};
      4'b00_11: u = '{op: ADD, src_a: X, src_b: Y, dst: R};
      4'b01_00: u = '{op: MUL, src_a: X, src_b: Y, dst: X};
      4'b01_01: u = '{op: ADD, src_a: X, src_b: Z, dst: R};
      4'b10_00: u = '{op: ADD, src_a: X, src_b: Y, dst: X};
      4'b10_01: u = '{op: DIV, src_a: X, src_b: Z, dst: R};
      4'b11_00: u = '{op: SUB, src_a: X, src_b: Y, dst: X};
      4'b11_01: u = '{op: MUL, src_a: X, src_b: Z, dst: R};
      default:  u = UOP_NOP;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/equation_checker_alu.sv
// eq_alu: combinational unsigned ALU; all results wrap to WIDTH bits and a
// zero divisor yields all-ones with div_zero raised.
module eq_alu
  import eq_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             div_zero
);

  always_comb begin
    y        = a;
    div_zero = 1'b0;
    case (op)
      ADD: y = a + b;
      SUB: y = a - b;
      MUL: y = a * b;
      DIV: begin
        if (b == '0) begin
          y        = '1;
          div_zero = 1'b1;
        end else begin
          y = a / b;
        end
      end
      default: y = a;
    endcase
  end

endmodule

// File: rtl/equation_checker.sv
// equation_checker: three-operand entry, 4-step micro-programmed evaluation,
// compare against latched target. Optional entry timeout: EQ_CHECKER_TIMEOUT_EN.
module equation_checker
  import eq_checker_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TARGET_W       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [1:0]          Mode,
  input  logic                Go,
  input  logic [WIDTH-1:0]    DataIn,
  input  logic [TARGET_W-1:0] OngoingTimer,
  input  logic                Ack,
  output logic                Busy,
  output logic [1:0]          OperandIdx,
  output logic                Done,
  output logic                Correct,
  output logic                DivZero,
  output logic                TimedOut,
  output logic [WIDTH-1:0]    Result
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, r_q, r_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       step_q, step_d;
  logic             div_zero_q, div_zero_d;
  logic             correct_q, correct_d;
  logic [WIDTH-1:0] result_q, result_d;

  micro_op_t        uop;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             alu_dz;

`ifdef EQ_CHECKER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timed_out_q, timed_out_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  eq_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (uop.op),
    .a       (alu_a),
    .b       (alu_b),
    .y       (alu_y),
    .div_zero(alu_dz)
  );

  always_comb begin
    uop = get_uop(mode_q, step_q);
    case (uop.src_a)
      X:       alu_a = x_q;
      Y:       alu_a = y_q;
      Z:       alu_a = z_q;
      default: alu_a = r_q;
    endcase
    case (uop.src_b)
      X:       alu_b = x_q;
      Y:       alu_b = y_q;
      Z:       alu_b = z_q;
      default: alu_b = r_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    target_d   = target_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    r_d        = r_q;
    idx_d      = idx_q;
    step_d     = step_q;
    div_zero_d = div_zero_q;
    correct_d  = correct_q;
    result_d   = result_q;
`ifdef EQ_CHECKER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timed_out_d = timed_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d    = LOAD;
          mode_d     = Mode;
          target_d   = WIDTH'(OngoingTimer);
          x_d        = '0;
          y_d        = '0;
          z_d        = '0;
          r_d        = '0;
          idx_d      = '0;
          div_zero_d = 1'b0;
          correct_d  = 1'b0;
          result_d   = '0;
`ifdef EQ_CHECKER_TIMEOUT_EN
          tmo_cnt_d   = '0;
          timed_out_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (Go) begin
          case (idx_q)
            2'd0:    x_d = DataIn;
            2'd1:    y_d = DataIn;
            default: z_d = DataIn;
          endcase
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (!Go) begin
          if (idx_q == 2'd2) begin
            state_d = CALC;
            step_d  = '0;
          end else begin
            idx_d   = 2'(idx_q + 2'd1);
            state_d = LOAD;
          end
        end
      end
      CALC: begin
        if (uop.op != NOP) begin
          case (uop.dst)
            X:       x_d = alu_y;
            Y:       y_d = alu_y;
            Z:       z_d = alu_y;
            default: r_d = alu_y;
          endcase
          if (alu_dz) div_zero_d = 1'b1;
        end
        step_d = 2'(step_q + 2'd1);
        if (step_q == 2'd3) state_d = COMPARE;
      end
      COMPARE: begin
        correct_d = (r_q == target_q) && !div_zero_q;
        result_d  = r_q;
        state_d   = DONE;
      end
      DONE: begin
        if (Ack) begin
          state_d   = IDLE;
          correct_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef EQ_CHECKER_TIMEOUT_EN
    // A load restarts the window; expiry overrides any entry-state transition.
    if (state_q == LOAD || state_q == LOAD_WAIT) begin
      if (state_q == LOAD && Go) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = DONE;
        timed_out_d = 1'b1;
        correct_d   = 1'b0;
        result_d    = '0;
      end else begin
        tmo_cnt_d = TMO_W'(tmo_cnt_q + 1'b1);
      end
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      target_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      step_q     <= '0;
      div_zero_q <= 1'b0;
      correct_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      target_q   <= target_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      div_zero_q <= div_zero_d;
      correct_q  <= correct_d;
      result_q   <= result_d;
    end
  end

`ifdef EQ_CHECKER_TIMEOUT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmo_cnt_q   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
  assign TimedOut = timed_out_q;
`else
  assign TimedOut = 1'b0;
`endif

  assign Busy       = (state_q != IDLE);
  assign OperandIdx = (state_q == LOAD || state_q == LOAD_WAIT) ? idx_q : 2'd0;
  assign Done       = (state_q == DONE);
  assign Correct    = correct_q;
  assign DivZero    = div_zero_q;
  assign Result     = result_q;

endmodule

// File: tb/tb_equation_checker.sv
// Randomised scoreboard bench for equation_checker (default build, WIDTH=8).
module tb_equation_checker;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] Mode = '0;
  logic       Go = 1'b0;
  logic [7:0] DataIn = '0;
  logic [6:0] OngoingTimer = '0;
  logic       Ack = 1'b0;
  logic       Busy;
  logic [1:0] OperandIdx;
  logic       Done;
  logic       Correct;
  logic       DivZero;
  logic       TimedOut;
  logic [7:0] Result;

  equation_checker #(.WIDTH(8), .TARGET_W(7), .TIMEOUT_CYCLES(1000)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Go(Go),
    .DataIn(DataIn), .OngoingTimer(OngoingTimer), .Ack(Ack), .Busy(Busy),
    .OperandIdx(OperandIdx), .Done(Done), .Correct(Correct), .DivZero(DivZero),
    .TimedOut(TimedOut), .Result(Result)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int res;
    bit cor;
    bit dz;
    int rel;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the four equations evaluated directly, wrapping mod 256.
  function automatic void model(input int mode, input int x, input int y, input int z,
                                input int t, output int res, output bit cor, output bit dz);
    int a, b;
    dz = 1'b0;
    case (mode)
      0: begin
        if (z == 0) begin a = 255; b = 255; dz = 1'b1; end
        else begin a = x / z; b = y / z; end
        res = ((a * a) % 256 + b) % 256;
      end
      1: res = (x * y + z) % 256;
      2: begin
        a = (x + y) % 256;
        if (z == 0) begin res = 255; dz = 1'b1; end
        else res = a / z;
      end
      default: res = (((x - y + 256) % 256) * z) % 256;
    endcase
    cor = (res == t) && !dz;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: pops one expectation per rising Done.
  logic done_prev = 1'b0;
  always @(negedge Clock) begin : mon
    exp_t e;
    if (Done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending question (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", int'(Result), e.res);
        check("correct", int'(Correct), int'(e.cor));
        check("divzero", int'(DivZero), int'(e.dz));
        check("timedout", int'(TimedOut), 0);
        check("done_latency", cyc - e.rel, 5);
      end
    end
    done_prev = Done;
  end

  task automatic do_question(input int mode, input int x, input int y, input int z,
                             input int t, input bit go_pre, input bit ack_start);
    int ops[3];
    int res, n;
    bit cor, dz;
    exp_t e;
    ops[0] = x; ops[1] = y; ops[2] = z;
    model(mode, x, y, z, t, res, cor, dz);
    Start = 1'b1;
    Mode = 2'(mode);
    OngoingTimer = 7'(t);
    if (go_pre) begin Go = 1'b1; DataIn = 8'(x); end
    step();
    Start = 1'b0;
    Mode = 2'($urandom);
    OngoingTimer = 7'($urandom);
    check("busy_after_start", int'(Busy), 1);
    check("idx_after_start", int'(OperandIdx), 0);
    check("result_cleared", int'(Result), 0);
    check("divzero_cleared", int'(DivZero), 0);
    for (int i = 0; i < 3; i++) begin
      DataIn = 8'(ops[i]);
      Go = 1'b1;
      step();
      n = $urandom_range(0, 3);
      for (int h = 0; h < n; h++) begin
        DataIn = 8'($urandom);
        step();
        check("idx_while_held", int'(OperandIdx), i);
      end
      Go = 1'b0;
      DataIn = 8'($urandom);
      if (i == 2) begin
        e.res = res; e.cor = cor; e.dz = dz; e.rel = cyc + 1;
        sb_q.push_back(e);
      end
      step();
      if (i < 2) begin
        check("idx_after_release", int'(OperandIdx), i + 1);
        n = $urandom_range(0, 2);
        for (int l = 0; l < n; l++) begin
          step();
          check("idx_waiting_press", int'(OperandIdx), i + 1);
        end
      end
    end
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("done_seen", int'(Done === 1'b1), 1);
    for (int h = 0; h < 2; h++) begin
      step();
      check("done_hold", int'(Done), 1);
      check("result_hold", int'(Result), res);
    end
    Ack = 1'b1;
    Start = ack_start;
    step();
    Ack = 1'b0;
    Start = 1'b0;
    check("done_after_ack", int'(Done), 0);
    check("busy_after_ack", int'(Busy), 0);
    check("correct_after_ack", int'(Correct), 0);
    check("result_after_ack", int'(Result), res);
    check("divzero_after_ack", int'(DivZero), int'(dz));
    if (ack_start) begin
      step();
      check("start_with_ack_ignored", int'(Busy), 0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int m, x, y, z, t, res;
    bit cor, dz;
    repeat (2) step();
    check("rst_busy", int'(Busy), 0);
    check("rst_idx", int'(OperandIdx), 0);
    check("rst_done", int'(Done), 0);
    check("rst_correct", int'(Correct), 0);
    check("rst_divzero", int'(DivZero), 0);
    check("rst_timedout", int'(TimedOut), 0);
    check("rst_result", int'(Result), 0);
    Reset = 1'b0;
    step();

    do_question(0, 8, 6, 2, 19, 1'b0, 1'b0);
    do_question(1, 16, 16, 0, 0, 1'b0, 1'b0);
    do_question(2, 5, 3, 0, 127, 1'b0, 1'b1);
    do_question(3, 2, 5, 1, 5, 1'b0, 1'b0);
    do_question(0, 200, 9, 7, 3, 1'b1, 1'b0);

    // Abort mid-entry: reset while Go is still held in LOAD_WAIT.
    Start = 1'b1; Mode = 2'd1; OngoingTimer = 7'd9;
    step();
    Start = 1'b0; Go = 1'b1; DataIn = 8'd77;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; Go = 1'b0;
    check("midrst_busy", int'(Busy), 0);
    check("midrst_idx", int'(OperandIdx), 0);
    check("midrst_done", int'(Done), 0);
    check("midrst_correct", int'(Correct), 0);
    check("midrst_divzero", int'(DivZero), 0);
    check("midrst_timedout", int'(TimedOut), 0);
    check("midrst_result", int'(Result), 0);
    repeat (12) step();
    check("midrst_stays_idle", int'(Busy), 0);

    for (int k = 0; k < 30; k++) begin
      m = $urandom_range(0, 3);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      z = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      model(m, x, y, z, 0, res, cor, dz);
      t = ($urandom_range(0, 1) == 1 && res < 128) ? res : $urandom_range(0, 127);
      do_question(m, x, y, z, t, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (3) step();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
# equation_checker

Parametrised successor to the single-equation checker in the quiz path. It captures three operands one per Go press, evaluates one of four selectable equations on a shared sequential ALU, and compares the result against the OngoingTimer value latched at start. It sits between the keypad/switch input logic and the VGA feedback logic. It reports Correct/DivZero with a Done/Ack handshake instead of self-resetting.

## Interface
- WIDTH, 8: operand, ALU and result width.
- TARGET_W, 7: OngoingTimer width; must be ≤ WIDTH.
- TIMEOUT_CYCLES, 1_000_000: operand-entry timeout (used only with macro).
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a question; sampled only in IDLE.
- Mode  in  2  equation select; latched on Start.
- Go  in  1  operand-entry strobe (level, press/release).
- DataIn  in  WIDTH  operand value.
- OngoingTimer  in  TARGET_W  target; zero-extended and latched on Start.
- Ack  in  1  consumer has read result; sampled only in DONE.
- Busy  out  1  high in every state except IDLE.
- OperandIdx  out  2  operand being awaited (0=x, 1=y, 2=z); 0 outside LOAD/LOAD_WAIT.
- Done  out  1  result valid; held until Ack.
- Correct  out  1  result == target and no DivZero; valid while Done.
- DivZero  out  1  a divide with zero divisor occurred this question.
- TimedOut  out  1  entry aborted by timeout; tied 0 without macro.
- Result  out  WIDTH  computed value.

## Operation
- States: IDLE, LOAD, LOAD_WAIT, CALC, COMPARE, DONE.
- IDLE: Start=1 → LOAD. Latch Mode and target, clear x/y/z/r/DivZero/TimedOut, idx=0.
- LOAD: Go=1 → load operand[idx] ← DataIn, go to LOAD_WAIT.
- LOAD_WAIT: Go=0 → idx<2: idx++, LOAD; idx==2: CALC with step=0.
- Go already high on entry to LOAD loads immediately; one press loads exactly one operand.
- CALC: 4 fixed steps (step 0..3). Each step is one micro-op {op, srcA, srcB, dst} from the Mode table. NOP steps leave registers unchanged.
  - Mode 0: x←x/z; x←x*x; y←y/z; r←x+y.
  - Mode 1: x←x*y; r←x+z; NOP; NOP.
  - Mode 2: x←x+y; r←x/z; NOP; NOP.
  - Mode 3: x←x−y; r←x*z; NOP; NOP.
- ALU ops ADD, SUB, MUL, DIV are unsigned. Results truncate to low WIDTH bits (wrap mod 2^WIDTH). SUB wraps.
- DIV by 0: result all-ones; sets sticky DivZero.
- COMPARE: Correct ← (r == target) && !DivZero. Result ← r.
- DONE: Done=1. Ack=1 → IDLE and clear Done/Correct. Result, DivZero and TimedOut hold until the next Start.
- Start outside IDLE and Ack outside DONE are ignored.

## Timing
- Reset: state IDLE; all registers 0. Every output is 0: Busy, OperandIdx, Done, Correct, DivZero, TimedOut, Result.
- Reset mid-question aborts immediately; no Done is produced.
- Reset has priority over all other inputs.
- Go-release sampled for z at edge k: CALC occupies cycles k+1..k+4, COMPARE k+5, Done=1 from k+6.
- Start sampled at edge s: Busy=1 and OperandIdx=0 from s+1.
- Ack and Start in the same DONE cycle: Ack only. Start needs a fresh IDLE sample.

## Configuration
- EQ_CHECKER_TIMEOUT_EN defined: a counter runs in LOAD and LOAD_WAIT and resets on each operand load.
  - Reaching TIMEOUT_CYCLES → DONE with TimedOut=1, Correct=0, Result=0, no CALC.
- Macro undefined: no counter; TimedOut constant 0; entry waits indefinitely.

## Structure
- Package eq_checker_pkg holds:
  - state enum;
  - alu_op_e {ADD, SUB, MUL, DIV, NOP};
  - reg_sel_e {X, Y, Z, R};
  - micro-op struct;
  - constant function returning the micro-op for (mode, step).
- One sub-module, eq_alu: combinational, parametrised by WIDTH, outputs result and div-by-zero flag.

## Test plan
- Mode 0, x=8, y=6, z=2, timer=19 → Done six cycles after last Go release; Result=19, Correct=1, DivZero=0.
- Mode 1, x=16, y=16, z=0, WIDTH=8, timer=0 → Result=0 (256 wraps), Correct=1.
- Mode 2, x=5, y=3, z=0, timer=127 → Result=255, DivZero=1, Correct=0.
- Mode 3, x=2, y=5, z=1, timer=5 → Result=253 (wrap), Correct=0; Done holds until Ack, then Busy=0.
- Go held high across two LOAD visits for a single press → only x loaded, OperandIdx stays 1 until release/press. Reset asserted during LOAD_WAIT → all outputs 0 next cycle.
- With EQ_CHECKER_TIMEOUT_EN and TIMEOUT_CYCLES=10, Start then no Go → Done and TimedOut=1 at cycle 11, Correct=0.
